// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding (common to TX and RX), parity selects, data width.
package uart_pkg;

   localparam int DATA_W = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity makes the total count of ones even; odd inverts that bit.
   function automatic logic calcParity(input logic [DATA_W-1:0] data, input logic parTyp);
      return (^data) ^ (parTyp == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period tick generator: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_o on the wrap cycle.
module uart_tx_baud_gen #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic bit_tick_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] tickCnt_q, tickCnt_d;

   always_comb begin
      tickCnt_d = tickCnt_q;
      if (clear_i) begin
         tickCnt_d = '0;
      end else if (enable_i) begin
         tickCnt_d = (tickCnt_q == LAST) ? '0 : tickCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tickCnt_q <= '0;
      end else begin
         tickCnt_q <= tickCnt_d;
      end
   end

   assign bit_tick_o = enable_i && (tickCnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit; Busy qualifies the frame.
// Define UART_TX_HOLD_EN to add a one-entry holding register allowing back-to-back frames.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 1,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] P_DATA,
   input  logic              DATA_VALID,
   input  logic              PAR_EN,
   input  logic              PAR_TYP,
   output logic              TX_OUT,
   output logic              Busy,
   output logic              TX_READY
);

   import uart_pkg::*;

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bitCnt_q, bitCnt_d;
   logic              parEn_q, parEn_d;
   logic              parity_q, parity_d;
   logic              txOut_q, txOut_d;
   logic              busy_q, busy_d;

   logic              bitTick;
   logic              accept;
   logic              load;
   logic              stopDone;
   logic [DATA_W-1:0] loadData;
   logic              loadParEn;
   logic              loadParTyp;

   assign accept   = DATA_VALID && TX_READY;
   assign stopDone = (state_q == STOP) && bitTick;

`ifdef UART_TX_HOLD_EN
   logic              holdValid_q, holdValid_d;
   logic [DATA_W-1:0] holdData_q, holdData_d;
   logic              holdParEn_q, holdParEn_d;
   logic              holdParTyp_q, holdParTyp_d;
   logic              fromHold, direct, capture;

   assign TX_READY = ~holdValid_q;
   assign fromHold = stopDone && holdValid_q;
   // A byte accepted in the final STOP cycle with the hold register empty goes straight to the shifter.
   assign direct   = accept && ((state_q == IDLE) || (stopDone && !holdValid_q));
   assign capture  = accept && !direct;
   assign load     = fromHold || direct;

   always_comb begin
      loadData   = P_DATA;
      loadParEn  = PAR_EN;
      loadParTyp = PAR_TYP;
      if (fromHold) begin
         loadData   = holdData_q;
         loadParEn  = holdParEn_q;
         loadParTyp = holdParTyp_q;
      end
   end

   always_comb begin
      holdValid_d  = holdValid_q;
      holdData_d   = holdData_q;
      holdParEn_d  = holdParEn_q;
      holdParTyp_d = holdParTyp_q;
      if (fromHold) begin
         holdValid_d = 1'b0;
      end
      if (capture) begin
         holdValid_d  = 1'b1;
         holdData_d   = P_DATA;
         holdParEn_d  = PAR_EN;
         holdParTyp_d = PAR_TYP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         holdValid_q  <= 1'b0;
         holdData_q   <= '0;
         holdParEn_q  <= 1'b0;
         holdParTyp_q <= 1'b0;
      end else begin
         holdValid_q  <= holdValid_d;
         holdData_q   <= holdData_d;
         holdParEn_q  <= holdParEn_d;
         holdParTyp_q <= holdParTyp_d;
      end
   end
`else
   assign TX_READY   = ~busy_q;
   assign load       = accept;
   assign loadData   = P_DATA;
   assign loadParEn  = PAR_EN;
   assign loadParTyp = PAR_TYP;
`endif

   uart_tx_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (load),
      .enable_i  (state_q != IDLE),
      .bit_tick_o(bitTick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load) state_d = START;
         START:   if (bitTick) state_d = DATA;
         DATA:    if (bitTick && (bitCnt_q == LAST_BIT)) state_d = parEn_q ? PARITY : STOP;
         PARITY:  if (bitTick) state_d = STOP;
         STOP:    if (bitTick) state_d = load ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d  = shift_q;
      bitCnt_d = bitCnt_q;
      parEn_d  = parEn_q;
      parity_d = parity_q;
      if (load) begin
         shift_d  = loadData;
         bitCnt_d = '0;
         parEn_d  = loadParEn;
         parity_d = calcParity(loadData, loadParTyp);
      end else if ((state_q == DATA) && bitTick) begin
         shift_d  = shift_q >> 1;
         bitCnt_d = bitCnt_q + 3'd1;
      end
   end

   // Outputs are decoded from next state so the registered line lines up with the state it belongs to.
   always_comb begin
      txOut_d = 1'b1;
      busy_d  = (state_d != IDLE);
      unique case (state_d)
         IDLE:    txOut_d = 1'b1;
         START:   txOut_d = 1'b0;
         DATA:    txOut_d = shift_d[0];
         PARITY:  txOut_d = parity_d;
         STOP:    txOut_d = 1'b1;
         default: txOut_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         bitCnt_q <= '0;
         parEn_q  <= 1'b0;
         parity_q <= 1'b0;
         txOut_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         bitCnt_q <= bitCnt_d;
         parEn_q  <= parEn_d;
         parity_q <= parity_d;
         txOut_q  <= txOut_d;
         busy_q   <= busy_d;
      end
   end

   assign TX_OUT = txOut_q;
   assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: one instance at 1 clk/bit, one at 4 clk/bit.
// Expected frames come from a bit-list model built from the framing rules.
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pData;
   logic       dv1, dv4;
   logic       parEn, parTyp;
   logic       tx1, busy1, rdy1;
   logic       tx4, busy4, rdy4;

   int checks = 0;
   int errors = 0;
   bit expQ[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
      .clk(clk), .reset(reset), .P_DATA(pData), .DATA_VALID(dv1), .PAR_EN(parEn),
      .PAR_TYP(parTyp), .TX_OUT(tx1), .Busy(busy1), .TX_READY(rdy1)
   );

   uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
      .clk(clk), .reset(reset), .P_DATA(pData), .DATA_VALID(dv4), .PAR_EN(parEn),
      .PAR_TYP(parTyp), .TX_OUT(tx4), .Busy(busy4), .TX_READY(rdy4)
   );

   function automatic logic txOf(input int sel);
      return (sel == 4) ? tx4 : tx1;
   endfunction

   function automatic logic busyOf(input int sel);
      return (sel == 4) ? busy4 : busy1;
   endfunction

   function automatic logic rdyOf(input int sel);
      return (sel == 4) ? rdy4 : rdy1;
   endfunction

   // Model: start 0, data LSB first, parity making total ones even (or odd), stop 1.
   function automatic void buildFrame(input logic [7:0] d, input logic pe, input logic pt);
      int ones;
      ones = $countones(d);
      expQ.push_back(1'b0);
      for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
      if (pe) expQ.push_back(((ones % 2) == 1) ^ pt);
      expQ.push_back(1'b1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setDv(input int sel, input logic v);
      if (sel == 4) dv4 = v;
      else dv1 = v;
   endtask

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyReset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         step();
         checkOutput("rst_tx", tx1, 1'b1);
         checkOutput("rst_busy", busy1, 1'b0);
         checkOutput("rst_ready", rdy1, 1'b1);
         checkOutput("rst_tx4", tx4, 1'b1);
      end
      reset = 1'b0;
   endtask

   // Waits (bounded) for an idle DUT, offers one byte for one cycle, then scrambles the inputs.
   task automatic applyStimulus(input int sel, input logic [7:0] d, input logic pe, input logic pt);
      int waitCnt;
      waitCnt = 0;
      while (!(rdyOf(sel) && !busyOf(sel)) && waitCnt < 200) begin
         step();
         waitCnt++;
      end
      checkOutput("idle_before_offer", rdyOf(sel) && !busyOf(sel), 1'b1);
      pData  = d;
      parEn  = pe;
      parTyp = pt;
      setDv(sel, 1'b1);
      step();
      setDv(sel, 1'b0);
      pData  = 8'($urandom);
      parEn  = 1'($urandom);
      parTyp = 1'($urandom);
   endtask

   // Walks the expected frame cycle by cycle, optionally re-offering another byte the whole time.
   task automatic checkFrame(input int sel, input int cpb, input logic [7:0] d,
                             input logic offerOther, input logic [7:0] other);
      logic [7:0] rxByte;
      logic       expBit;
      int         bitIdx;
      int         busyCycles;
      int         frameLen;
      rxByte     = '0;
      bitIdx     = 0;
      busyCycles = 0;
      frameLen   = expQ.size() * cpb;
      while (expQ.size() > 0) begin
         expBit = expQ.pop_front();
         for (int c = 0; c < cpb; c++) begin
            if (offerOther) begin
               pData = other;
               setDv(sel, 1'b1);
            end
            checkOutput("tx_bit", txOf(sel), expBit);
            if (busyOf(sel)) busyCycles++;
            if ((c == cpb / 2) && (bitIdx >= 1) && (bitIdx <= 8)) rxByte[bitIdx-1] = txOf(sel);
            step();
         end
         bitIdx++;
      end
      setDv(sel, 1'b0);
      checkOutput("busy_low_after_stop", busyOf(sel), 1'b0);
      checkOutput("line_idle_after_stop", txOf(sel), 1'b1);
      checkInt("busy_cycles", busyCycles, frameLen);
      checkInt("rx_byte", int'(rxByte), int'(d));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic       pe, pt;
      reset  = 1'b1;
      dv1    = 1'b0;
      dv4    = 1'b0;
      pData  = '0;
      parEn  = 1'b0;
      parTyp = 1'b0;

      applyReset(3);

      // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1 over 10 cycles.
      buildFrame(8'hA5, 1'b0, 1'b0);
      applyStimulus(1, 8'hA5, 1'b0, 1'b0);
      checkFrame(1, 1, 8'hA5, 1'b0, 8'h00);

      // Parity on 0x07: even gives 1, odd gives 0.
      buildFrame(8'h07, 1'b1, 1'b0);
      applyStimulus(1, 8'h07, 1'b1, 1'b0);
      checkFrame(1, 1, 8'h07, 1'b0, 8'h00);
      buildFrame(8'h07, 1'b1, 1'b1);
      applyStimulus(1, 8'h07, 1'b1, 1'b1);
      checkFrame(1, 1, 8'h07, 1'b0, 8'h00);

      // Reset while idle.
      step();
      applyReset(3);

`ifdef UART_TX_HOLD_EN
      // 0x11 then 0x22 offered during frame 1: frames abut, Busy high for 20 cycles.
      buildFrame(8'h11, 1'b0, 1'b0);
      buildFrame(8'h22, 1'b0, 1'b0);
      applyStimulus(1, 8'h11, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         checkOutput("hold_tx", tx1, expQ[i]);
         checkOutput("hold_busy", busy1, 1'b1);
         checkOutput("hold_ready", rdy1, ((i >= 1) && (i <= 9)) ? 1'b0 : 1'b1);
         if (i == 0) begin
            pData  = 8'h22;
            parEn  = 1'b0;
            parTyp = 1'b0;
            dv1    = 1'b1;
         end
         step();
         dv1 = 1'b0;
      end
      expQ.delete();
      checkOutput("hold_busy_end", busy1, 1'b0);
      checkOutput("hold_tx_end", tx1, 1'b1);
`else
      // 0x3C sent while 0xFF is offered throughout the frame: 0xFF must be ignored.
      buildFrame(8'h3C, 1'b0, 1'b0);
      applyStimulus(1, 8'h3C, 1'b0, 1'b0);
      checkFrame(1, 1, 8'h3C, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("ignored_offer_tx", tx1, 1'b1);
         checkOutput("ignored_offer_busy", busy1, 1'b0);
      end
      buildFrame(8'hFF, 1'b0, 1'b0);
      applyStimulus(1, 8'hFF, 1'b0, 1'b0);
      checkFrame(1, 1, 8'hFF, 1'b0, 8'h00);
`endif

      // Reset mid-frame: line returns high and no stop bit follows.
      applyStimulus(1, 8'hC3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      applyReset(3);
      for (int i = 0; i < 15; i++) begin
         checkOutput("abort_tx", tx1, 1'b1);
         checkOutput("abort_busy", busy1, 1'b0);
         step();
      end

      // 4 clocks per bit: 0x81 held 4 cycles per bit, 40-cycle frame.
      buildFrame(8'h81, 1'b0, 1'b0);
      applyStimulus(4, 8'h81, 1'b0, 1'b0);
      checkFrame(4, 4, 8'h81, 1'b0, 8'h00);

      for (int n = 0; n < 8; n++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         buildFrame(d, pe, pt);
         applyStimulus(1, d, pe, pt);
         checkFrame(1, 1, d, 1'b0, 8'h00);
      end

      for (int n = 0; n < 3; n++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         buildFrame(d, pe, pt);
         applyStimulus(4, d, pe, pt);
         checkFrame(4, 4, d, 1'b0, 8'h00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
